tft_spi_monitor: RTL
====================

// Module: tft_spi_monitor
// PURPOSE
//  Receive side of the TFT SPI link. Passively sniffs the 4-wire bus that tft_spi drives
//  (clk/mosi/dc/cs, as mirrored on the analyzer_* pins). Rebuilds bytes MSB-first, tags each
//  byte with dc and its parameter index, and buffers them in a FIFO for a debug/checker consumer.
//  Also tracks the last command opcode and counts RAMWR pixel bytes. Never drives the bus.
// PARAMETERS
//  FIFO_DEPTH  16  record FIFO entries; power of two, >=2
//  PIX_CNT_W   24  width of ramwr_bytes counter
// PORTS
//  clk          in   1          system clock
//  rst          in   1          reset: synchronous, active-low; clock clk
//  spi_clk      in   1          sniffed SPI clock, async to clk, idle low (mode 0)
//  spi_mosi     in   1          sniffed data, async
//  spi_dc       in   1          sniffed data/command: 0=command, 1=data; async
//  spi_cs       in   1          sniffed chip select, active-low; async
//  out_valid    out  1          FIFO head record valid
//  out_ready    in   1          consumer accepts head when out_valid&&out_ready
//  out_data     out  8          received byte
//  out_dc       out  1          dc sampled with the byte
//  out_pidx     out  4          param index: 0 for a command; 0..15 for data after it (saturating)
//  last_cmd     out  8          most recent dc=0 byte
//  ramwr_bytes  out  PIX_CNT_W  data bytes received since last RAMWR (0x2C)
//  overflow     out  1          sticky: a byte was dropped because the FIFO was full
//  frag_err     out  1          one-cycle pulse: cs rose with 1..7 bits pending
// BEHAVIOUR
//  Reset (rst=0 at posedge clk): FIFO emptied; out_valid=0; out_data/out_dc/out_pidx=0;
//   last_cmd=8'h00; ramwr_bytes=0; overflow=0; frag_err=0; bit count=0; synchronizer regs=0.
//   Reset mid-byte discards partial bits without a frag_err pulse.
//  Input sync: all four inputs pass through 2-FF synchronizers; edge detect on synced spi_clk.
//   Requirement on the bus: spi_clk high and low phases each >=2 clk periods. mosi/dc must be
//   stable from 3 clk periods before each rising spi_clk edge.
//  Shift: on a synced spi_clk rising edge with synced cs=0: shift mosi into the LSB and bump the
//   3-bit count. On the 8th bit (count 7->0), the byte completes; dc is taken at that same edge.
//   Rising spi_clk while cs=1 is ignored.
//  cs=1: count cleared every cycle. If count!=0 on the cs 0->1 synced transition, pulse frag_err.
//   Partial bits are never pushed.
//  Timing: byte completes in cycle N (the edge-detect cycle). The FIFO is written at the end of N.
//   If the FIFO was empty, out_valid=1 in N+1 with the record on out_*.
//  FIFO: show-ahead; out_* show the head, or 0 when empty. Pop when out_valid&&out_ready.
//   Push is accepted if not full, or if full with a pop in the same cycle.
//   Otherwise the byte is dropped and overflow is set, cleared only by reset.
//   Ordering is strict FIFO.
//  Decoder (works on every completed byte, even a dropped one):
//   dc=0: last_cmd<=byte; pidx<=1 (index for next data); record pidx=0; if byte==CMD_RAMWR,
//     ramwr_bytes<=0.
//   dc=1: record pidx=current pidx; pidx<=min(pidx+1,15).
//     If last_cmd==CMD_RAMWR: ramwr_bytes<=ramwr_bytes+1, saturating at all-ones.
//   Data before any command: last_cmd=0, pidx starts at 0.
//  No internal FSM states beyond count/cs tracking; the block is a pipeline:
//   sync -> edge -> shift -> decode -> FIFO.
// STRUCTURE
//  tft_pkg: CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C; record layout {pidx[3:0],dc,data[7:0]}
//   (13 bits) and its width constant. The opcode list is shared with tft_init/scene_exhibitor.
//  Sub-module sync_fifo (WIDTH, DEPTH; push/full, pop/empty, show-ahead) is instantiated once.
//  Synchronizers, shifter and decoder stay inline.
// TESTING
//  1 cs=0, send dc=0 0x2A then dc=1 0x00,0x10 at spi_clk=clk/8 ->
//    records {0,0,2A},{1,1,00},{2,1,10}; last_cmd=2A.
//  2 cmd 0x2C then 300 data bytes, out_ready=1 -> ramwr_bytes=300; 17th+ data byte pidx=15;
//    a new 0x2C resets the count to 0.
//  3 out_ready=0, send 20 bytes, FIFO_DEPTH=16 -> 16 records kept in order, overflow=1
//    after the 17th byte; decoder counts all 20.
//  4 FIFO full, byte completes in the same cycle as a pop -> byte accepted, overflow stays 0.
//  5 cs=0, 5 clocks, cs=1 -> frag_err single pulse, no record; next full byte decoded correctly.
//  6 rst=0 mid-byte with 3 records queued -> next cycle out_valid=0, all outputs at reset
//    values; a fresh byte after release decodes cleanly.

Source files
------------

// File: rtl/tft_pkg.sv
// ---------------------------------------------------------------------------
// tft_pkg
// Shared definitions for the TFT SPI blocks (tft_init, scene_exhibitor,
// tft_spi_monitor): the command opcodes and the monitor's record layout.
// No ports.
// ---------------------------------------------------------------------------
package tft_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    // Record pushed into the monitor FIFO for every received byte.
    typedef struct packed {
        logic [3:0] pidx;
        logic       dc;
        logic [7:0] data;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    localparam logic [3:0] PIDX_MAX = 4'hF;

    // Next parameter index, held at PIDX_MAX once reached.
    function automatic logic [3:0] pidx_next(input logic [3:0] p);
        return (p == PIDX_MAX) ? p : p + 4'd1;
    endfunction

endpackage

// File: rtl/tft_spi_monitor_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO. The head entry is always visible on pop_data
// (zero while empty). A push while full is still taken when a pop happens in
// the same cycle, because the pop frees the slot at the same edge.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   push          write push_data at the end of this cycle if there is room
//   push_data     entry to write
//   full          DEPTH entries held
//   pop           consume the head entry (ignored when empty)
//   pop_data      head entry, or 0 when empty
//   empty         no entries held
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tft_spi_monitor.sv
// ---------------------------------------------------------------------------
// tft_spi_monitor
// Passive receiver for the TFT SPI link (mode 0, MSB first). Rebuilds bytes,
// tags each with dc and a parameter index, and queues the records for a
// debug consumer. Also tracks the last command and counts RAMWR pixel bytes.
// Pipeline: 2-FF sync -> spi_clk edge detect -> shifter -> decoder -> FIFO.
// Ports:
//   clk, rst               system clock, synchronous active-low reset
//   spi_clk/mosi/dc/cs     sniffed bus, asynchronous to clk, cs active-low
//   out_valid/out_ready    record handshake: the head record moves when both
//                          are high at a clk edge; out_valid stays high and
//                          the record stays put until accepted
//   out_data/dc/pidx       head record fields, 0 when no record is queued
//   last_cmd               most recent command byte (dc=0)
//   ramwr_bytes            data bytes since the last RAMWR, saturating
//   overflow               sticky: a byte was dropped on a full FIFO
//   frag_err               one-cycle pulse: cs rose mid-byte
// ---------------------------------------------------------------------------
module tft_spi_monitor
    import tft_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int PIX_CNT_W  = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_clk,
    input  logic                 spi_mosi,
    input  logic                 spi_dc,
    input  logic                 spi_cs,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 out_dc,
    output logic [3:0]           out_pidx,
    output logic [7:0]           last_cmd,
    output logic [PIX_CNT_W-1:0] ramwr_bytes,
    output logic                 overflow,
    output logic                 frag_err
);

    // ---------------- input synchronizers ----------------
    logic [1:0] sclk_sync;
    logic [1:0] mosi_sync;
    logic [1:0] dc_sync;
    logic [1:0] cs_sync;
    logic       sclk_prev;
    logic       cs_prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            dc_sync   <= '0;
            cs_sync   <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_clk};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            dc_sync   <= {dc_sync[0], spi_dc};
            cs_sync   <= {cs_sync[0], spi_cs};
            sclk_prev <= sclk_sync[1];
            cs_prev   <= cs_sync[1];
        end
    end

    logic sclk_s, mosi_s, dc_s, cs_s;
    logic sclk_rise, cs_rise;

    assign sclk_s    = sclk_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign dc_s      = dc_sync[1];
    assign cs_s      = cs_sync[1];
    assign sclk_rise = sclk_s && !sclk_prev;
    assign cs_rise   = cs_s && !cs_prev;

    // ---------------- shifter ----------------
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic       byte_done;
    logic [7:0] byte_val;

    // The eighth bit is taken straight from the synchronizer so the byte is
    // complete in the edge-detect cycle itself.
    assign byte_done = sclk_rise && !cs_s && (bit_cnt == 3'd7);
    assign byte_val  = {shreg, mosi_s};

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            frag_err <= 1'b0;
        end else begin
            // bit_cnt still holds the pending count in the cs_rise cycle.
            frag_err <= cs_rise && (bit_cnt != 3'd0);
            if (cs_s) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                shreg   <= {shreg[5:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // ---------------- decoder ----------------
    logic [3:0]           pidx;
    rec_t                 rec_in;
    rec_t                 rec_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;

    always_comb begin
        rec_in      = '0;
        rec_in.data = byte_val;
        rec_in.dc   = dc_s;
        rec_in.pidx = dc_s ? pidx : 4'd0;
    end

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_cmd    <= 8'h00;
            pidx        <= 4'd0;
            ramwr_bytes <= '0;
            overflow    <= 1'b0;
        end else begin
            // The decoder follows every completed byte, stored or dropped.
            if (byte_done) begin
                if (!dc_s) begin
                    last_cmd <= byte_val;
                    pidx     <= 4'd1;
                    if (byte_val == CMD_RAMWR) ramwr_bytes <= '0;
                end else begin
                    pidx <= pidx_next(pidx);
                    if (last_cmd == CMD_RAMWR && ramwr_bytes != '1)
                        ramwr_bytes <= ramwr_bytes + PIX_CNT_W'(1);
                end
                if (fifo_full && !pop) overflow <= 1'b1;
            end
        end
    end

    // ---------------- record FIFO ----------------
    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (byte_done),
        .push_data (rec_in),
        .full      (fifo_full),
        .pop       (pop),
        .pop_data  (rec_head),
        .empty     (fifo_empty)
    );

    assign out_data = rec_head.data;
    assign out_dc   = rec_head.dc;
    assign out_pidx = rec_head.pidx;

endmodule
